rs232_rxb_ctrl: RTL and testbench

Read-side controller for the buffered RS232 receiver. Owns the receive FIFO's `rd` strobe, prefetches the head byte into a holding register and routes it to one of two consumers: the CPU I/O register or an auxiliary valid/ready byte stream, such as a command interpreter. It also keeps receive statistics: a sticky overrun flag, a received-byte counter and an optional line-idle flag. It sits between the buffered receiver and the I/O bus decode.

---
 rtl/rs232_rxb_ctrl.sv | 163 ++++++++++++++++
 tb/tb_rs232_rxb_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rs232_rxb_ctrl.sv
// Read-side controller for the buffered RS232 receiver: prefetches the FIFO head and routes it to the CPU or the aux stream.
// Optional line-idle detector is enabled by defining RXB_CTRL_IDLE_EN.
module rs232_rxb_ctrl #(
    parameter int cnt_width      = 16,
    parameter int timeout_cycles = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic                 fifo_full,
    input  logic [7:0]           fifo_data,
    output logic                 fifo_rd,
    input  logic                 cpu_rd,
    output logic [7:0]           cpu_data,
    output logic                 cpu_avail,
    output logic                 aux_valid,
    output logic [7:0]           aux_data,
    input  logic                 aux_ready,
    input  logic                 sel_wr,
    input  logic                 sel_in,
    output logic                 sel_cur,
    input  logic                 stat_clr,
    output logic                 overrun,
    output logic [cnt_width-1:0] byte_cnt,
    output logic                 idle
);

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SWAP} state_t;

    if (timeout_cycles < 2) begin : g_param_chk
        $error("timeout_cycles must be at least 2");
    end

    state_t                state_q, state_d;
    logic                  sel_q, sel_d;
    logic                  pend_q, pend_d;
    logic                  pend_sel_q, pend_sel_d;
    logic [7:0]            hold_q, hold_d;
    logic                  full_q;
    logic                  overrun_q, overrun_d;
    logic [cnt_width-1:0]  cnt_q, cnt_d;
    logic                  sw_pend;
    logic                  consume;

    assign sw_pend = pend_q | sel_wr;
    assign consume = (~sel_q & cpu_rd) | (sel_q & aux_ready);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        hold_d     = hold_q;
        fifo_rd    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (sw_pend) begin
                    state_d = ST_SWAP;
                end else if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    hold_d  = fifo_data;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // A pending switch blocks the same-cycle refill so the owner can change between bytes.
                if (consume) begin
                    if (!fifo_empty && !sw_pend) begin
                        fifo_rd = 1'b1;
                        hold_d  = fifo_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            ST_SWAP: begin
                sel_d   = pend_sel_q;
                pend_d  = 1'b0;
                state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (sel_wr) begin
            pend_d     = 1'b1;
            pend_sel_d = sel_in;
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (fifo_full && !full_q) overrun_d = 1'b1;
        else if (stat_clr)        overrun_d = 1'b0;
        cnt_d = stat_clr ? '0 : cnt_q;
        if (fifo_rd) cnt_d = cnt_d + cnt_width'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            sel_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_sel_q <= 1'b0;
            hold_q     <= 8'h00;
            full_q     <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            hold_q     <= hold_d;
            full_q     <= fifo_full;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign sel_cur   = sel_q;
    assign cpu_avail = (state_q == ST_FULL) & ~sel_q;
    assign aux_valid = (state_q == ST_FULL) & sel_q;
    assign cpu_data  = cpu_avail ? hold_q : 8'h00;
    assign aux_data  = aux_valid ? hold_q : 8'h00;
    assign overrun   = overrun_q;
    assign byte_cnt  = cnt_q;

`ifdef RXB_CTRL_IDLE_EN
    localparam int ICW = $clog2(timeout_cycles + 1);

    logic           armed_q, armed_d;
    logic [ICW-1:0] icnt_q, icnt_d;

    always_comb begin
        armed_d = armed_q;
        icnt_d  = icnt_q;
        if (fifo_rd) begin
            armed_d = 1'b1;
            icnt_d  = '0;
        end else if (stat_clr) begin
            armed_d = 1'b0;
            icnt_d  = '0;
        end else if (armed_q && state_q == ST_EMPTY && fifo_empty &&
                     icnt_q != ICW'(timeout_cycles)) begin
            icnt_d = icnt_q + ICW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            icnt_q  <= '0;
        end else begin
            armed_q <= armed_d;
            icnt_q  <= icnt_d;
        end
    end

    assign idle = (icnt_q == ICW'(timeout_cycles));
`else
    assign idle = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_rxb_ctrl.sv
// Directed, table-driven bench for rs232_rxb_ctrl (cnt_width=4, timeout_cycles=10).
module tb_rs232_rxb_ctrl;

`ifdef RXB_CTRL_IDLE_EN
    localparam bit IDLE_ON = 1'b1;
`else
    localparam bit IDLE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty, fifo_full, cpu_rd, aux_ready, sel_wr, sel_in, stat_clr;
    logic [7:0] fifo_data;
    logic       fifo_rd, cpu_avail, aux_valid, sel_cur, overrun, idle;
    logic [7:0] cpu_data, aux_data;
    logic [3:0] byte_cnt;

    int checks = 0;
    int fails  = 0;

    rs232_rxb_ctrl #(.cnt_width(4), .timeout_cycles(10)) dut (
        .clk(clk), .rst(rst),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .cpu_rd(cpu_rd), .cpu_data(cpu_data), .cpu_avail(cpu_avail),
        .aux_valid(aux_valid), .aux_data(aux_data), .aux_ready(aux_ready),
        .sel_wr(sel_wr), .sel_in(sel_in), .sel_cur(sel_cur),
        .stat_clr(stat_clr), .overrun(overrun), .byte_cnt(byte_cnt), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fe, ff;
        logic [7:0] fd;
        logic       crd, ardy, swr, sin, sclr;
        logic       rd, cav;
        logic [7:0] cd;
        logic       av;
        logic [7:0] ad;
        logic       sel, ovr;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[39];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fe, input logic ff, input logic [7:0] fd, input logic crd,
                         input logic ardy, input logic swr, input logic sin, input logic sclr);
        fifo_empty = fe; fifo_full = ff; fifo_data = fd; cpu_rd = crd;
        aux_ready = ardy; sel_wr = swr; sel_in = sin; stat_clr = sclr;
    endtask

    initial begin
        //           fe ff fd    crd ardy swr sin sclr  rd cav cd    av ad    sel ovr cnt
        vecs[0]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0};
        vecs[1]  = '{0, 0, 8'hA5, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 8'h00, 0, 0, 0};
        vecs[2]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'hA5, 0, 8'h00, 0, 0, 1};
        vecs[3]  = '{1, 0, 8'h00, 1, 0, 0, 0, 0,   0, 1, 8'hA5, 0, 8'h00, 0, 0, 1};
        vecs[4]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 0, 0, 1};
        vecs[5]  = '{1, 0, 8'h00, 0, 0, 1, 1, 0,   0, 0, 8'h00, 0, 8'h00, 0, 0, 1};
        vecs[6]  = '{1, 0, 8'h00, 0, 0, 0, 0, 1,   0, 0, 8'h00, 0, 8'h00, 0, 0, 1};
        vecs[7]  = '{0, 0, 8'h01, 0, 1, 0, 0, 0,   1, 0, 8'h00, 0, 8'h00, 1, 0, 0};
        vecs[8]  = '{0, 0, 8'h02, 0, 1, 0, 0, 0,   1, 0, 8'h00, 1, 8'h01, 1, 0, 1};
        vecs[9]  = '{0, 0, 8'h03, 0, 1, 0, 0, 0,   1, 0, 8'h00, 1, 8'h02, 1, 0, 2};
        vecs[10] = '{0, 0, 8'h04, 0, 1, 0, 0, 0,   1, 0, 8'h00, 1, 8'h03, 1, 0, 3};
        vecs[11] = '{1, 0, 8'h00, 0, 1, 0, 0, 0,   0, 0, 8'h00, 1, 8'h04, 1, 0, 4};
        vecs[12] = '{0, 0, 8'h05, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 8'h00, 1, 0, 4};
        vecs[13] = '{1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 1, 8'h05, 1, 0, 5};
        vecs[14] = '{0, 0, 8'h66, 0, 0, 0, 0, 0,   0, 0, 8'h00, 1, 8'h05, 1, 0, 5};
        vecs[15] = '{0, 0, 8'h66, 1, 0, 0, 0, 0,   0, 0, 8'h00, 1, 8'h05, 1, 0, 5};
        vecs[16] = '{1, 0, 8'h00, 0, 1, 0, 0, 0,   0, 0, 8'h00, 1, 8'h05, 1, 0, 5};
        vecs[17] = '{1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 1, 0, 5};
        vecs[18] = '{1, 0, 8'h00, 0, 0, 1, 0, 0,   0, 0, 8'h00, 0, 8'h00, 1, 0, 5};
        vecs[19] = '{1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 1, 0, 5};
        vecs[20] = '{0, 0, 8'h3C, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 8'h00, 0, 0, 5};
        vecs[21] = '{0, 0, 8'h77, 0, 1, 1, 1, 0,   0, 1, 8'h3C, 0, 8'h00, 0, 0, 6};
        vecs[22] = '{0, 0, 8'h77, 0, 0, 0, 0, 0,   0, 1, 8'h3C, 0, 8'h00, 0, 0, 6};
        vecs[23] = '{0, 0, 8'h77, 1, 0, 0, 0, 0,   0, 1, 8'h3C, 0, 8'h00, 0, 0, 6};
        vecs[24] = '{0, 0, 8'h77, 1, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 0, 0, 6};
        vecs[25] = '{0, 0, 8'h77, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 0, 0, 6};
        vecs[26] = '{0, 0, 8'h77, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 8'h00, 1, 0, 6};
        vecs[27] = '{1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 1, 8'h77, 1, 0, 7};
        vecs[28] = '{1, 0, 8'h00, 0, 1, 0, 0, 0,   0, 0, 8'h00, 1, 8'h77, 1, 0, 7};
        vecs[29] = '{1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 1, 0, 7};
        vecs[30] = '{1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 1, 0, 7};
        vecs[31] = '{1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 1, 1, 7};
        vecs[32] = '{1, 1, 8'h00, 0, 0, 0, 0, 1,   0, 0, 8'h00, 0, 8'h00, 1, 1, 7};
        vecs[33] = '{1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 1, 0, 0};
        vecs[34] = '{1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 1, 0, 0};
        vecs[35] = '{1, 1, 8'h00, 0, 0, 0, 0, 1,   0, 0, 8'h00, 0, 8'h00, 1, 0, 0};
        vecs[36] = '{1, 1, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 1, 1, 0};
        vecs[37] = '{1, 0, 8'h00, 0, 0, 0, 0, 1,   0, 0, 8'h00, 0, 8'h00, 1, 1, 0};
        vecs[38] = '{1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 1, 0, 0};

        rst = 1'b1;
        drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 39; i++) begin
            @(negedge clk);
            drive(vecs[i].fe, vecs[i].ff, vecs[i].fd, vecs[i].crd,
                  vecs[i].ardy, vecs[i].swr, vecs[i].sin, vecs[i].sclr);
            #1;
            chk($sformatf("v%0d.fifo_rd", i),   16'(fifo_rd),   16'(vecs[i].rd));
            chk($sformatf("v%0d.cpu_avail", i), 16'(cpu_avail), 16'(vecs[i].cav));
            chk($sformatf("v%0d.cpu_data", i),  16'(cpu_data),  16'(vecs[i].cd));
            chk($sformatf("v%0d.aux_valid", i), 16'(aux_valid), 16'(vecs[i].av));
            chk($sformatf("v%0d.aux_data", i),  16'(aux_data),  16'(vecs[i].ad));
            chk($sformatf("v%0d.sel_cur", i),   16'(sel_cur),   16'(vecs[i].sel));
            chk($sformatf("v%0d.overrun", i),   16'(overrun),   16'(vecs[i].ovr));
            chk($sformatf("v%0d.byte_cnt", i),  16'(byte_cnt),  16'(vecs[i].cnt));
            chk($sformatf("v%0d.idle", i),      16'(idle),      16'd0);
        end

        // Back-to-back aux stream: 17 pops on a 4-bit counter wraps through zero to 1.
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            drive(0, 0, 8'(i), 0, 1, 0, 0, 0);
            #1;
            chk($sformatf("wrap%0d.fifo_rd", i), 16'(fifo_rd), 16'd1);
            chk($sformatf("wrap%0d.byte_cnt", i), 16'(byte_cnt), 16'((i - 1) % 16));
            if (i > 1) chk($sformatf("wrap%0d.aux_data", i), 16'(aux_data), 16'(i - 1));
        end
        @(negedge clk);
        drive(1, 0, 8'h00, 0, 1, 0, 0, 0);
        #1;
        chk("wrap_last.aux_data", 16'(aux_data), 16'h11);
        chk("wrap_last.fifo_rd", 16'(fifo_rd), 16'd0);
        @(negedge clk);
        drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
        #1;
        chk("wrap.byte_cnt", 16'(byte_cnt), 16'd1);
        chk("wrap.aux_valid", 16'(aux_valid), 16'd0);

        // Idle detector: clear, one byte in and out, then count empty cycles.
        @(negedge clk);
        drive(1, 0, 8'h00, 0, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 8'hAB, 0, 0, 0, 0, 0);
        #1;
        chk("idle.fetch_rd", 16'(fifo_rd), 16'd1);
        @(negedge clk);
        drive(1, 0, 8'h00, 0, 1, 0, 0, 0);
        #1;
        chk("idle.aux_data", 16'(aux_data), 16'hAB);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("idle.pre%0d", i), 16'(idle), 16'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("idle.set%0d", i), 16'(idle), 16'(IDLE_ON));
        end
        @(negedge clk);
        drive(0, 0, 8'hCD, 0, 0, 0, 0, 0);
        #1;
        chk("idle.new_byte_rd", 16'(fifo_rd), 16'd1);
        @(negedge clk);
        drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
        #1;
        chk("idle.cleared", 16'(idle), 16'd0);
        chk("idle.aux_data", 16'(aux_data), 16'hCD);

        // Reset in the middle of operation drops the held byte and the owner.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.aux_valid", 16'(aux_valid), 16'd0);
        chk("rst.sel_cur", 16'(sel_cur), 16'd0);
        chk("rst.byte_cnt", 16'(byte_cnt), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
